mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 36, request/memory address width.
REQ-002 Parameter LINE_W, default 128, cache-line data width.
REQ-003 Parameter TIMEOUT, default 255, max BUSY cycles waiting for mem_ack.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 ic_req / dc_req  input  1 each  icache / dcache miss request, held until own done.
REQ-007 ic_addr / dc_addr  input  ADDR_W each  line address of request.
REQ-008 dc_we  input  1  dcache request is a line write (icache is read-only).
REQ-009 dc_wdata  input  LINE_W  dcache write line.
REQ-010 ic_done / dc_done  output  1 each  one-cycle completion pulse to requester.
REQ-011 rdata  output  LINE_W  returned line, valid when either done is high.
REQ-012 mem_req  output  1  memory request, high for whole transaction.
REQ-013 mem_we, mem_addr, mem_wdata  output  1/ADDR_W/LINE_W  latched request fields.
REQ-014 mem_ack  input  1  one-cycle memory completion; mem_rdata valid same cycle.
REQ-015 mem_rdata  input  LINE_W  memory read line.
REQ-016 err  output  1  sticky timeout flag.

Function
REQ-017 FSM states IDLE, BUSY_I, BUSY_D, RESP; one transaction in flight at most.
REQ-018 IDLE: only dc_req -> BUSY_D; only ic_req -> BUSY_I; neither -> stay IDLE.
REQ-019 IDLE, both requests: grant requester not in last_grant register (round-robin); last_grant updated on every grant.
REQ-020 On grant, latch addr, we (0 for icache), wdata into mem_* registers; mem_req=1 from first BUSY cycle.
REQ-021 mem_ack ignored outside BUSY_*; in BUSY_*, ack -> RESP, mem_rdata captured into rdata, mem_req drops next cycle.
REQ-022 RESP lasts exactly one cycle; asserts done of granted requester only; then IDLE.
REQ-023 Latency: req high in IDLE at cycle 0, mem_req high cycle 1, ack at cycle k, done at k+1, IDLE at k+2; ack at cycle 1 is legal (done cycle 2).
REQ-024 Requester deasserts req in cycle after done; req high in IDLE is always a new request (back-to-back allowed).
REQ-025 Requester dropping req mid-BUSY does not abort; transaction completes and done still pulses.
REQ-026 rdata holds last value outside RESP; for writes rdata = mem_rdata at ack (don't-care to requesters).
REQ-027 Timeout counter clears on entering BUSY_*, increments each BUSY cycle without ack; reaching TIMEOUT -> RESP with rdata=0, done pulsed, err set.
REQ-028 err stays 1 until rst; arbitration continues normally after timeout.
REQ-029 Ack arriving on same cycle counter reaches TIMEOUT is a success; err not set.

Reset
REQ-030 rst asserted forces immediately: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, ic_done=dc_done=0, err=0, counter=0, last_grant=ICACHE (first tie goes to dcache).
REQ-031 Reset mid-transaction aborts it; no done pulse issued; mem_ack during reset ignored.

Structure
REQ-032 Shared package mem_arb_pkg holds state enum, requester enum {ICACHE, DCACHE}, default ADDR_W/LINE_W/TIMEOUT.
REQ-033 Timeout counter is sub-module arb_timeout (clear, enable, expired outputs); all else in mem_arbiter.

Verification
REQ-034 dc_req, dc_addr=0x000000040, dc_we=1, ack at cycle 3 -> mem_req cycles 1-3, mem_we=1, dc_done cycle 4, ic_done stays 0.
REQ-035 ic_req and dc_req both high from reset, each re-requests after done -> grants D,I,D,I alternate; no starvation.
REQ-036 ic_req, mem_rdata=0xDEADBEEF_..._0123 with ack at cycle 1 -> ic_done cycle 2, rdata equals mem_rdata.
REQ-037 TIMEOUT=4, never ack -> RESP after 4 BUSY cycles, done pulse, rdata=0, err=1 and stays 1 across later good transaction.
REQ-038 rst asserted mid-BUSY_D -> mem_req low immediately, no dc_done, err=0, next tie grants dcache.
REQ-039 ic_req dropped cycle 2 of BUSY_I, ack cycle 5 -> ic_done still pulses cycle 6; stray mem_ack in IDLE causes no done.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//
// Purpose : Shared types and default sizing for the icache/dcache memory
//           arbiter.
//           - arb_state_t : arbiter FSM states
//           - requester_t : which cache owns the current/last grant
//           - DEF_*       : default address width, line width, timeout
// Ports   : none (package)
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEF_ADDR_W  = 36;
    localparam int DEF_LINE_W  = 128;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } requester_t;

    // Round-robin helper: the requester that did not win last time.
    function automatic requester_t other_requester(input requester_t r);
        return (r == ICACHE) ? DCACHE : ICACHE;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//
// Purpose : Bundles the requester-side and memory-side signals of the
//           arbiter.
// Modports:
//   master - the arbiter itself: consumes the cache requests and memory
//            responses, drives done/rdata/err and the mem_* request.
//   slave  - the environment (caches + memory model): the mirror image.
// Signals:
//   ic_req, ic_addr                      icache miss request
//   dc_req, dc_addr, dc_we, dc_wdata     dcache miss/write request
//   ic_done, dc_done, rdata              completion pulses and returned line
//   mem_req, mem_we, mem_addr, mem_wdata memory request
//   mem_ack, mem_rdata                   memory completion and read line
//   err                                  sticky timeout flag
// ---------------------------------------------------------------------------
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
);

    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              dc_req;
    logic [ADDR_W-1:0] dc_addr;
    logic              dc_we;
    logic [LINE_W-1:0] dc_wdata;

    logic              ic_done;
    logic              dc_done;
    logic [LINE_W-1:0] rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_rdata;

    logic              err;

    modport master (
        input  ic_req, ic_addr, dc_req, dc_addr, dc_we, dc_wdata,
        input  mem_ack, mem_rdata,
        output ic_done, dc_done, rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output err
    );

    modport slave (
        output ic_req, ic_addr, dc_req, dc_addr, dc_we, dc_wdata,
        output mem_ack, mem_rdata,
        input  ic_done, dc_done, rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  err
    );

endinterface

// File: rtl/mem_arbiter_timeout.sv
// ---------------------------------------------------------------------------
// arb_timeout
//
// Purpose : Counts BUSY cycles that pass without a memory acknowledge and
//           flags the cycle in which the count reaches TIMEOUT.
// Ports   :
//   clk     in  clock
//   rst     in  asynchronous active-high reset
//   clear   in  restart the count (transaction granted)
//   enable  in  a BUSY cycle without mem_ack
//   expired out this enabled cycle is the TIMEOUT-th one
// ---------------------------------------------------------------------------
module arb_timeout
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // Combinational so that an ack in the same cycle (which drops enable)
    // always wins over the timeout.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose : Shares one memory port between an icache (read-only) and a
//           dcache (read/write). One transaction in flight at a time;
//           simultaneous requests are resolved round-robin. A transaction
//           that waits TIMEOUT cycles for mem_ack is completed with a zero
//           line and sets the sticky err flag.
// Params  : ADDR_W, LINE_W, TIMEOUT
// Ports   :
//   clk  in  clock
//   rst  in  asynchronous active-high reset
//   bus  mem_arbiter_if.master - request, memory and completion signals
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LINE_W  = DEF_LINE_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    arb_state_t        state;
    arb_state_t        next_state;
    requester_t        last_grant;
    requester_t        grant_who;
    logic              grant_valid;
    logic              capture_ack;
    logic              capture_timeout;
    logic              in_busy;
    logic              tmo_expired;

    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [LINE_W-1:0] mem_wdata_q;
    logic [LINE_W-1:0] rdata_q;
    logic              err_q;

    assign in_busy = (state == BUSY_I) || (state == BUSY_D);

    arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (grant_valid),
        .enable  (in_busy && !bus.mem_ack),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state      = state;
        grant_valid     = 1'b0;
        grant_who       = last_grant;
        capture_ack     = 1'b0;
        capture_timeout = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.ic_req && bus.dc_req) begin
                    grant_valid = 1'b1;
                    grant_who   = other_requester(last_grant);
                end else if (bus.dc_req) begin
                    grant_valid = 1'b1;
                    grant_who   = DCACHE;
                end else if (bus.ic_req) begin
                    grant_valid = 1'b1;
                    grant_who   = ICACHE;
                end

                if (grant_valid) begin
                    next_state = (grant_who == DCACHE) ? BUSY_D : BUSY_I;
                end
            end

            BUSY_I, BUSY_D: begin
                // Ack takes priority: an ack on the expiring cycle is a success.
                if (bus.mem_ack) begin
                    next_state  = RESP;
                    capture_ack = 1'b1;
                end else if (tmo_expired) begin
                    next_state      = RESP;
                    capture_timeout = 1'b1;
                end
            end

            RESP: begin
                next_state = IDLE;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request fields are latched at grant so the requester may drop or change
    // its inputs while the memory transaction is outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant  <= ICACHE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            if (grant_valid) begin
                last_grant <= grant_who;
                if (grant_who == DCACHE) begin
                    mem_we_q    <= bus.dc_we;
                    mem_addr_q  <= bus.dc_addr;
                    mem_wdata_q <= bus.dc_wdata;
                end else begin
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= bus.ic_addr;
                    mem_wdata_q <= '0;
                end
            end

            if (capture_ack) begin
                rdata_q <= bus.mem_rdata;
            end else if (capture_timeout) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    // last_grant still names the owner of the transaction while in RESP.
    assign bus.ic_done   = (state == RESP) && (last_grant == ICACHE);
    assign bus.dc_done   = (state == RESP) && (last_grant == DCACHE);
    assign bus.rdata     = rdata_q;
    assign bus.mem_req   = in_busy;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.err       = err_q;

endmodule
